// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage bundle: PC link, imem request/response, decode handoff
//
// Ports (signals):
//   pc_out, pc_next_in         : PC to / next PC from PC_adder
//   imem_req_valid/ready, imem_addr, imem_rsp_valid, imem_rsp_data : instruction memory
//   instr_valid, decode_ready, instr_out, instr_pc : decode handoff
//   fetch_count, instr_misaligned : status
// master: fetch stage side; slave: surrounding core / memory / decode side.
interface instruction_fetch_if;
   logic [31:0] pc_out;
   logic [31:0] pc_next_in;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        decode_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic [31:0] fetch_count;
   logic        instr_misaligned;

   modport master (
      output pc_out, imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
             fetch_count, instr_misaligned,
      input  pc_next_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, decode_ready
   );

   modport slave (
      input  pc_out, imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
             fetch_count, instr_misaligned,
      output pc_next_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, decode_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - SEQ core fetch stage: PC register, imem read, decode handoff
//
// Ports:
//   clk   : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : instruction_fetch_if.master (PC link, imem channel, decode handoff, status)
// Parameters: RESET_PC (PC after reset), NOP_INSTR (instr_out while nothing is held).
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-PC trap to a sticky FAULT state).
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   instruction_fetch_if.master   bus
);

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic [31:0] count_q;

   // Every entry into REQ goes through here so the alignment check sees the
   // PC that the request would actually use (pc_next_in on a handshake).
`ifdef FETCH_MISALIGN_CHECK_EN
   logic [31:0] req_pc;
   state_t      req_entry;
   assign req_pc    = (state == HOLD) ? bus.pc_next_in : pc_q;
   assign req_entry = (req_pc[1:0] != 2'b00) ? FAULT : REQ;
`else
   state_t      req_entry;
   assign req_entry = REQ;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; FAULT (when present) falls into default and is left only by reset.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = req_entry;
         REQ:     if (bus.imem_req_ready) state_next = WAIT;
         WAIT:    if (bus.imem_rsp_valid) state_next = HOLD;
         HOLD:    if (bus.decode_ready)   state_next = req_entry;
         default: state_next = state;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      bus.imem_req_valid   = (state == REQ);
      bus.instr_valid      = (state == HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
      bus.instr_misaligned = (state == FAULT);
`else
      bus.instr_misaligned = 1'b0;
`endif
   end

   // Datapath: PC and count move only on a decode handshake, so PC_adder
   // sees a stable PC for the whole life of an instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= 32'h0;
         count_q    <= 32'h0;
      end else begin
         case (state)
            WAIT: if (bus.imem_rsp_valid) begin
               instr_q    <= bus.imem_rsp_data;
               instr_pc_q <= pc_q;
            end
            HOLD: if (bus.decode_ready) begin
               pc_q    <= bus.pc_next_in;
               count_q <= count_q + 32'd1;
               instr_q <= NOP_INSTR;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc_out      = pc_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.fetch_count = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign bus.imem_addr   = pc_q;
`else
   // Memory only ever sees word addresses; the raw PC is kept architecturally.
   assign bus.imem_addr   = {pc_q[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_if bus();
   instruction_fetch dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad = 0;
   logic [31:0] exp_cnt = 32'h0;
   logic [31:0] addr_q[$];
   logic [95:0] ins_q[$];   // {instr, instr_pc, fetch_count}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever a request or a decode handshake is presented.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (addr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_req: got addr %h expected none", bus.imem_addr);
            end else chk("req_addr", bus.imem_addr, addr_q.pop_front());
         end
         if (bus.instr_valid && bus.decode_ready) begin
            if (ins_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_instr: got %h expected none", bus.instr_out);
            end else begin
               logic [95:0] e;
               e = ins_q.pop_front();
               chk("instr_out", bus.instr_out, e[95:64]);
               chk("instr_pc", bus.instr_pc, e[63:32]);
               chk("fetch_count_pre", bus.fetch_count, e[31:0]);
            end
         end
      end
   end

   // One instruction: optional request/response/decode stalls, stray responses in REQ and HOLD.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                        input logic [31:0] exp_ipc, input logic [31:0] next_pc,
                        input int req_wait, input int rsp_wait, input int dec_wait,
                        input int exp_lat);
      int lat = 0;
      int guard = 0;
      addr_q.push_back(exp_addr);
      ins_q.push_back({data, exp_ipc, exp_cnt});
      while (!bus.imem_req_valid && guard < 20) begin
         step(); lat++; guard++;
      end
      chk("req_seen", {31'h0, bus.imem_req_valid}, 32'h1);
      if (!bus.imem_req_valid) return;
      for (int i = 0; i < req_wait; i++) begin
         bus.imem_rsp_valid = (i == 0);
         bus.imem_rsp_data  = 32'hDEAD_0001;
         chk("req_valid_stall", {31'h0, bus.imem_req_valid}, 32'h1);
         chk("req_addr_stall", bus.imem_addr, exp_addr);
         step(); lat++;
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      step(); lat++;
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < rsp_wait; i++) begin
         chk("wait_no_valid", {30'h0, bus.imem_req_valid, bus.instr_valid}, 32'h0);
         step(); lat++;
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      step(); lat++;
      bus.imem_rsp_valid = 1'b0;
      chk("instr_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("latency", lat, exp_lat);
      for (int i = 0; i < dec_wait; i++) begin
         bus.imem_rsp_valid = (i == 1);
         bus.imem_rsp_data  = 32'hDEAD_0002;
         step();
         chk("hold_instr", bus.instr_out, data);
         chk("hold_pc", bus.pc_out, exp_ipc);
      end
      bus.imem_rsp_valid = 1'b0;
      bus.decode_ready = 1'b1;
      bus.pc_next_in   = next_pc;
      step();
      bus.decode_ready = 1'b0;
      bus.pc_next_in   = 32'hFFFF_FFF0;
      exp_cnt++;
      chk("pc_after", bus.pc_out, next_pc);
      chk("count_after", bus.fetch_count, exp_cnt);
      chk("instr_nop_after", bus.instr_out, NOP);
      chk("valid_low_after", {31'h0, bus.instr_valid}, 32'h0);
   endtask

   task automatic chk_reset_state();
      chk("rst_pc", bus.pc_out, 32'h0);
      chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
      chk("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
      chk("rst_misaligned", {31'h0, bus.instr_misaligned}, 32'h0);
      chk("rst_instr_out", bus.instr_out, NOP);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      chk("rst_count", bus.fetch_count, 32'h0);
   endtask

   initial begin
      bus.pc_next_in     = 32'h0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.decode_ready   = 1'b0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk_reset_state();

      // zero-wait fetch from cycle 0, then sequential step and branch target
      fetch(32'h0, 32'h0050_0093, 32'h0, 32'h4, 0, 0, 0, 3);
      fetch(32'h4, 32'h00A0_0113, 32'h4, 32'hC, 0, 0, 0, 2);
      // 4 request stalls + 3 response waits + 5 decode stalls: valid rises 7 cycles later
      fetch(32'hC, 32'h0020_81B3, 32'hC, 32'h10, 4, 3, 5, 9);
      chk("count_three", bus.fetch_count, 32'd3);

      // reset in WAIT, stray response in the following IDLE cycle
      addr_q.push_back(32'h10);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      reset = 1'b1;
      bus.decode_ready = 1'b1;
      step();
      reset = 1'b0;
      bus.decode_ready = 1'b0;
      exp_cnt = 32'h0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
      chk_reset_state();
      step();
      bus.imem_rsp_valid = 1'b0;
      chk("late_rsp_dropped", bus.instr_out, NOP);
      chk("late_rsp_no_valid", {31'h0, bus.instr_valid}, 32'h0);
      fetch(32'h0, 32'h0010_0073, 32'h0, 32'h6, 0, 0, 0, 2);

`ifdef FETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         chk("fault_flag", {31'h0, bus.instr_misaligned}, 32'h1);
         chk("fault_no_req", {30'h0, bus.imem_req_valid, bus.instr_valid}, 32'h0);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_cnt = 32'h0;
      chk("fault_cleared", {31'h0, bus.instr_misaligned}, 32'h0);
      fetch(32'h0, 32'h0030_8213, 32'h0, 32'h4, 0, 0, 0, 3);
`else
      chk("unaligned_no_fault", {31'h0, bus.instr_misaligned}, 32'h0);
      fetch(32'h4, 32'h0030_8213, 32'h6, 32'h8, 0, 0, 0, 2);
      chk("unaligned_instr_pc", bus.instr_pc, 32'h6);
`endif

      repeat (2) step();
      chk("addr_q_empty", addr_q.size(), 32'h0);
      chk("ins_q_empty", ins_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
